// File: rtl/mem_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface_if
// Description : Bundles the datapath-side and memory-side signals of
//               mem_interface.
//               Datapath side : bus_in, MARin, MDRin, start_rd, start_wr,
//                               mdr_out, busy, done
//               Memory side   : mem_addr, mem_din, mem_write, mem_dout
//               Modports      : slave  - the mem_interface block
//                               master - the CPU control unit, datapath and
//                                        memory that surround the block
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_interface_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [DATA_W-1:0] bus_in;
    logic              MARin;
    logic              MDRin;
    logic              start_rd;
    logic              start_wr;
    logic [DATA_W-1:0] mdr_out;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  bus_in, MARin, MDRin, start_rd, start_wr, mem_dout,
        output mdr_out, busy, done, mem_addr, mem_din, mem_write
    );

    modport master (
        output bus_in, MARin, MDRin, start_rd, start_wr, mem_dout,
        input  mdr_out, busy, done, mem_addr, mem_din, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface
// Description : CPU-side memory interface. Holds MAR and MDR and sequences
//               one read or write transaction at a time through
//               IDLE -> WAIT (WAIT_STATES cycles) -> ACCESS -> DONE.
//               Ports : clk    - system clock (rising edge)
//                       resetn - asynchronous active-low reset
//                       bus    - mem_interface_if.slave (bus, MAR/MDR load,
//                                start strobes, status, memory port)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_interface #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    mem_interface_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // The counter is loaded with WAIT_STATES-1 on entry to WAIT and leaves
    // WAIT once it reaches zero, giving exactly WAIT_STATES wait cycles.
    localparam int           c_WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]   c_WAIT_INIT   = 4'(c_WAIT_INIT_I);

    state_t            state_q, state_d;
    op_t               op_q,    op_d;
    logic [3:0]        wcnt_q,  wcnt_d;
    logic [DATA_W-1:0] mar_q,   mar_d;
    logic [DATA_W-1:0] mdr_q,   mdr_d;

    // Upper MAR bits are architecturally visible in the register but do not
    // reach the memory, so addresses wrap modulo 2**ADDR_W.
    logic              w_unused_mar_hi;
    assign w_unused_mar_hi = ^mar_q[DATA_W-1:ADDR_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
            wcnt_q  <= 4'd0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wcnt_d  = wcnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;

        case (state_q)
            S_IDLE: begin
                // Loads only happen here so MAR/MDR are frozen while a
                // transaction is in flight; a load together with a start
                // makes the transaction use the freshly loaded value.
                if (bus.MARin) mar_d = bus.bus_in;
                if (bus.MDRin) mdr_d = bus.bus_in;
                if (bus.start_wr || bus.start_rd) begin
                    op_d = bus.start_wr ? OP_WR : OP_RD;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = c_WAIT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                // Memory read is combinational; capture it at the closing edge.
                if (op_q == OP_RD) mdr_d = bus.mem_dout;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mdr_out   = mdr_q;
    assign bus.mem_din   = mdr_q;
    assign bus.mem_addr  = mar_q[ADDR_W-1:0];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_write = (state_q == S_ACCESS) && (op_q == OP_WR);

endmodule
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_interface
// Description : Self-checking bench for mem_interface. Two instances are
//               exercised: one with WAIT_STATES=1 and one with WAIT_STATES=0,
//               each attached to its own 512x32 memory model. Expected done
//               data and expected memory writes are queued by the stimulus
//               and consumed by a monitor whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_interface;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_interface_if #(.DATA_W(32), .ADDR_W(9)) ifa ();
    mem_interface_if #(.DATA_W(32), .ADDR_W(9)) ifz ();

    mem_interface #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(1)) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa)
    );

    mem_interface #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifz)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem1 [512];
    logic [31:0] mem0 [512];
    bit          init_done = 1'b0;

    assign ifa.mem_dout = mem1[ifa.mem_addr];
    assign ifz.mem_dout = mem0[ifz.mem_addr];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 512; i++) begin
                mem1[i] <= 32'hA000_0000 | i;
                mem0[i] <= 32'hB000_0000 | i;
            end
            init_done <= 1'b1;
        end else begin
            if (ifa.mem_write) mem1[ifa.mem_addr] <= ifa.mem_din;
            if (ifz.mem_write) mem0[ifz.mem_addr] <= ifz.mem_din;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] dq1 [$];
    logic [31:0] dq0 [$];
    wr_t         wq1 [$];
    wr_t         wq0 [$];
    int          checks = 0;
    int          errors = 0;
    int          ndone1 = 0;
    int          ndone0 = 0;
    int          exp_done1 = 0;
    int          exp_done0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    always @(negedge clk) begin
        wr_t w;
        logic [31:0] e;
        if (ifa.done) begin
            ndone1++;
            if (dq1.size() == 0) flag("dut1_unexpected_done");
            else begin
                e = dq1.pop_front();
                check("dut1_done_mdr", ifa.mdr_out, e);
            end
        end
        if (ifa.mem_write) begin
            if (wq1.size() == 0) flag("dut1_unexpected_write");
            else begin
                w = wq1.pop_front();
                check("dut1_wr_addr", {23'd0, ifa.mem_addr}, {23'd0, w.a});
                check("dut1_wr_data", ifa.mem_din, w.d);
            end
        end
        if (ifz.done) begin
            ndone0++;
            if (dq0.size() == 0) flag("dut0_unexpected_done");
            else begin
                e = dq0.pop_front();
                check("dut0_done_mdr", ifz.mdr_out, e);
            end
        end
        if (ifz.mem_write) begin
            if (wq0.size() == 0) flag("dut0_unexpected_write");
            else begin
                w = wq0.pop_front();
                check("dut0_wr_addr", {23'd0, ifz.mem_addr}, {23'd0, w.a});
                check("dut0_wr_data", ifz.mem_din, w.d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Drive DUT1 inputs for one cycle; returns at the next negedge with
    // inputs cleared (cycle 1 if a start was issued).
    task automatic a_cyc(input logic marin, input logic mdrin, input logic rd,
                         input logic wr, input logic [31:0] val);
        ifa.MARin    = marin;
        ifa.MDRin    = mdrin;
        ifa.start_rd = rd;
        ifa.start_wr = wr;
        ifa.bus_in   = val;
        @(negedge clk);
        ifa.MARin    = 1'b0;
        ifa.MDRin    = 1'b0;
        ifa.start_rd = 1'b0;
        ifa.start_wr = 1'b0;
        ifa.bus_in   = '0;
    endtask

    task automatic z_cyc(input logic marin, input logic mdrin, input logic rd,
                         input logic wr, input logic [31:0] val);
        ifz.MARin    = marin;
        ifz.MDRin    = mdrin;
        ifz.start_rd = rd;
        ifz.start_wr = wr;
        ifz.bus_in   = val;
        @(negedge clk);
        ifz.MARin    = 1'b0;
        ifz.MDRin    = 1'b0;
        ifz.start_rd = 1'b0;
        ifz.start_wr = 1'b0;
        ifz.bus_in   = '0;
    endtask

    task automatic push_d1(input logic [31:0] d);
        dq1.push_back(d);
        exp_done1++;
    endtask

    task automatic push_w1(input logic [8:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq1.push_back(w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ifa.bus_in = '0; ifa.MARin = 1'b0; ifa.MDRin = 1'b0;
        ifa.start_rd = 1'b0; ifa.start_wr = 1'b0;
        ifz.bus_in = '0; ifz.MARin = 1'b0; ifz.MDRin = 1'b0;
        ifz.start_rd = 1'b0; ifz.start_wr = 1'b0;

        step(); step();
        check("rst_mdr",   ifa.mdr_out,   32'h0);
        check("rst_addr",  {23'd0, ifa.mem_addr}, 32'h0);
        check("rst_busy",  {31'd0, ifa.busy},      32'h0);
        check("rst_done",  {31'd0, ifa.done},      32'h0);
        check("rst_wr",    {31'd0, ifa.mem_write}, 32'h0);
        resetn = 1'b1;
        step();

        // Write 0xDEADBEEF to 0x45, W=1
        a_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h45);
        a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("mar_load", {23'd0, ifa.mem_addr}, 32'h45);
        check("mdr_load", ifa.mdr_out, 32'hDEAD_BEEF);
        push_w1(9'h45, 32'hDEAD_BEEF);
        push_d1(32'hDEAD_BEEF);
        a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("wr_c1_busy",  {31'd0, ifa.busy},      32'h1);
        check("wr_c1_mwr",   {31'd0, ifa.mem_write}, 32'h0);
        step();
        check("wr_c2_mwr",   {31'd0, ifa.mem_write}, 32'h1);
        check("wr_c2_done",  {31'd0, ifa.done},      32'h0);
        step();
        check("wr_c3_done",  {31'd0, ifa.done},      32'h1);
        check("wr_c3_mwr",   {31'd0, ifa.mem_write}, 32'h0);
        step();
        check("wr_c4_busy",  {31'd0, ifa.busy},      32'h0);
        check("wr_mem45",    mem1[9'h45], 32'hDEAD_BEEF);

        // Read back into a cleared MDR
        a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("mdr_clear", ifa.mdr_out, 32'h0);
        push_d1(32'hDEAD_BEEF);
        a_cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); step(); step();
        check("rd_mdr_after", ifa.mdr_out, 32'hDEAD_BEEF);

        // Simultaneous start_rd and start_wr: write wins
        a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
        push_w1(9'h45, 32'h5555_AAAA);
        push_d1(32'h5555_AAAA);
        a_cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(); step(); step();
        check("both_mdr",   ifa.mdr_out, 32'h5555_AAAA);
        check("both_mem45", mem1[9'h45], 32'h5555_AAAA);

        // Loads and starts while busy are ignored
        a_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
        push_d1(32'hA000_0020);
        a_cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        a_cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h10);
        check("busy_mar_kept", {23'd0, ifa.mem_addr}, 32'h20);
        check("busy_no_write", {31'd0, ifa.mem_write}, 32'h0);
        step(); step(); step(); step(); step();
        check("busy_rd_mdr", ifa.mdr_out, 32'hA000_0020);

        // Address wrap, load and start in the same cycle
        a_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0203);
        check("wrap_addr", {23'd0, ifa.mem_addr}, 32'h3);
        push_w1(9'h003, 32'h1234);
        push_d1(32'h1234);
        a_cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234);
        step(); step(); step();
        check("wrap_mem3",   mem1[9'h003], 32'h1234);
        check("wrap_mem203", mem1[9'h1FF], 32'hA000_01FF);

        // Abort a write with reset during WAIT
        a_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h7);
        a_cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("abort_busy", {31'd0, ifa.busy}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_mdr",  ifa.mdr_out, 32'h0);
        check("abort_addr", {23'd0, ifa.mem_addr}, 32'h0);
        check("abort_busy0", {31'd0, ifa.busy},      32'h0);
        check("abort_done",  {31'd0, ifa.done},      32'h0);
        check("abort_mwr",   {31'd0, ifa.mem_write}, 32'h0);
        step(); step();
        resetn = 1'b1;
        step(); step();
        check("abort_mem7", mem1[9'h007], 32'hA000_0007);

        // Zero wait states: read then write on DUT0
        z_cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h30);
        dq0.push_back(32'hB000_0030); exp_done0++;
        z_cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("z_c1_busy", {31'd0, ifz.busy}, 32'h1);
        check("z_c1_done", {31'd0, ifz.done}, 32'h0);
        step();
        check("z_c2_done", {31'd0, ifz.done}, 32'h1);
        check("z_c2_busy", {31'd0, ifz.busy}, 32'h1);
        step();
        check("z_c3_busy", {31'd0, ifz.busy}, 32'h0);
        check("z_rd_mdr",  ifz.mdr_out, 32'hB000_0030);
        begin
            wr_t w;
            w.a = 9'h030;
            w.d = 32'h77;
            wq0.push_back(w);
        end
        dq0.push_back(32'h77); exp_done0++;
        z_cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h77);
        check("z_wr_c1_mwr", {31'd0, ifz.mem_write}, 32'h1);
        step(); step();
        check("z_wr_mem", mem0[9'h030], 32'h77);

        // Scoreboard drained, exact number of done pulses
        check("dq1_empty", dq1.size(), 32'd0);
        check("wq1_empty", wq1.size(), 32'd0);
        check("dq0_empty", dq0.size(), 32'd0);
        check("wq0_empty", wq0.size(), 32'd0);
        check("ndone1", ndone1, exp_done1);
        check("ndone0", ndone0, exp_done0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- CPU-side memory interface between the datapath bus and the 512x32 memory block.
- Holds the MAR and MDR registers.
- Sequences read and write transactions through a small FSM with a configurable wait-state counter that models memory latency.
- Returns a one-cycle done pulse to the control unit.
- Drives the memory's Address, Datain and Write inputs and consumes its Dataout.

Parameters:
- DATA_W, 32, data width of bus, MDR and memory word.
- ADDR_W, 9, memory address width; mem_addr = MAR[ADDR_W-1:0].
- WAIT_STATES, 1, idle cycles inserted before the access cycle; legal range 0..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- bus_in  input  DATA_W  value from BusMuxOut.
- MARin  input  1  load MAR from bus_in.
- MDRin  input  1  load MDR from bus_in.
- start_rd  input  1  request memory read at MAR into MDR.
- start_wr  input  1  request memory write of MDR to MAR.
- mdr_out  output  DATA_W  current MDR contents, to bus mux.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  ADDR_W  to memory Address.
- mem_din  output  DATA_W  to memory Datain.
- mem_write  output  1  to memory Write.
- mem_dout  input  DATA_W  from memory Dataout (combinational read).

Behaviour:
- Reset (resetn=0, asynchronous):
  - MAR=0, MDR=0, state=IDLE, wait counter=0.
  - busy=0, done=0, mem_write=0.
  - Reset mid-transaction aborts it; no write occurs after reset is asserted.
- Combinational outputs:
  - mem_addr = MAR[ADDR_W-1:0].
  - mem_din = MDR.
  - mdr_out = MDR.
  - busy = (state != IDLE).
  - done = (state == DONE).
  - mem_write = (state == ACCESS && op == WR).
- Register loads:
  - MAR and MDR load from bus_in on MARin/MDRin only in IDLE.
  - Loads are ignored in all other states, so MAR/MDR stay stable during a transaction.
  - MARin and MDRin may load together in the same cycle.
- FSM states:
  - IDLE:
    - start_wr=1 → latch op=WR; start_rd=1 (without start_wr) → latch op=RD. Write has priority when both are asserted.
    - Next state is WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else ACCESS.
    - A register load and a start in the same IDLE cycle is legal: the register updates at the same edge, and the transaction uses the new value.
  - WAIT: counter decrements each cycle; at counter=0 go to ACCESS.
  - ACCESS (exactly one cycle):
    - RD: MDR <= mem_dout at the closing edge.
    - WR: mem_write=1 for this cycle only, so memory captures MDR at MAR at the closing edge.
    - Next state is DONE.
  - DONE (one cycle): done=1, busy=1; next state IDLE.
  - start_rd/start_wr asserted outside IDLE are ignored; they are not queued.
- Latency: start sampled at edge 0 → WAIT cycles 1..W → ACCESS cycle W+1 → DONE cycle W+2.
  - For reads, MDR holds the read data from cycle W+2 onward.
  - Earliest next start is sampled in cycle W+3.
- Address width: MAR bits above ADDR_W-1 are held in the register but ignored; address 0x200 maps to word 0 (wrap-around).
- Illegal states: any state encoding outside IDLE/WAIT/ACCESS/DONE returns to IDLE next cycle with mem_write=0.

Test Plan:
- Reset then idle: resetn pulsed low mid-cycle → mdr_out=0, mem_addr=0, busy=0, done=0, mem_write=0 immediately (async); no write occurs with clk running.
- Write then read back (WAIT_STATES=1): MARin with bus_in=0x0000_0045; MDRin with 0xDEAD_BEEF; start_wr → mem_write=1 only in cycle 2, done in cycle 3. Then MDRin with 0; start_rd → mdr_out=0xDEADBEEF in the done cycle.
- Zero wait states (WAIT_STATES=0): start_rd → ACCESS in cycle 1, done in cycle 2; busy high in cycles 1-2 only.
- Simultaneous start_rd and start_wr in IDLE: write executes (mem_write pulse); MDR unchanged after done.
- Loads and starts during busy: MARin with 0x10 and start_rd asserted in WAIT → MAR unchanged, no second transaction, exactly one done pulse.
- Address wrap and abort: MAR=0x0000_0203, write 0x1234 → word 3 updated. Then start a write and assert resetn=0 in WAIT → mem_write never asserts, target word unchanged.
